// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and types for the instruction-fetch stage
//   INSTR_W / PC_STEP : instruction width and sequential PC increment
//   redir_sel_e       : which redirect source won arbitration
//   fq_entry_t        : one prefetch-queue slot {pc, instr}
package if_pkg;

    localparam int INSTR_W  = 32;
    localparam int PC_STEP  = 4;
    // Widest PC a queue entry can carry; narrower PCs are zero-extended.
    localparam int PC_W_MAX = 32;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        J    = 2'd2,
        JR   = 2'd3
    } redir_sel_e;

    typedef struct packed {
        logic [PC_W_MAX-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } fq_entry_t;

endpackage

// File: rtl/inst_rom_sync.sv
// rtl/inst_rom_sync.sv - synchronous instruction ROM with registered output
//   clk  : rising-edge clock
//   addr : word address, sampled every edge
//   dout : word at the address sampled on the previous edge
// Contents come from INIT, a flat image built from the program hex file
// (word k occupies bits [k*INSTR_W +: INSTR_W]).
module inst_rom_sync
    import if_pkg::*;
#(
    parameter int                               ROM_AW = 6,
    parameter logic [(2**ROM_AW)*INSTR_W-1:0]   INIT   = '0
) (
    input  logic                clk,
    input  logic [ROM_AW-1:0]   addr,
    output logic [INSTR_W-1:0]  dout
);

    localparam int WORD_SH = $clog2(INSTR_W);

    logic [INSTR_W-1:0] dout_d;
    logic [INSTR_W-1:0] dout_q;

    always_comb begin
        dout_d = INIT[{addr, {WORD_SH{1'b0}}} +: INSTR_W];
    end

    // Read data needs no reset: the fetch stage only looks at it while a
    // fetch is in flight.
    always_ff @(posedge clk) begin
        dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch: PC, redirect select, ROM and prefetch queue
//   clk, reset (async, active-low)
//   branch_taken/jump/jump_reg + branch_addr/jump_addr/jr_addr : redirect requests
//   id_ready    : ID consumes the head this cycle
//   if_valid    : head instruction present
//   instr_out, pc_out, next_pc_out : head contents, all zero when if_valid=0
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int                             PC_W     = 32,
    parameter int                             ROM_AW   = 6,
    parameter int                             DEPTH    = 2,
    parameter logic [PC_W-1:0]                RESET_PC = '0,
    parameter logic [(2**ROM_AW)*INSTR_W-1:0] ROM_INIT = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               branch_taken,
    input  logic               jump,
    input  logic               jump_reg,
    input  logic [PC_W-1:0]    branch_addr,
    input  logic [PC_W-1:0]    jump_addr,
    input  logic [PC_W-1:0]    jr_addr,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic [PC_W-1:0]    next_pc_out
);

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam int                OCC_W    = CNT_W + 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    ipc_q, ipc_d;        // PC of the fetch in flight
    logic               inflight_q, inflight_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    fq_entry_t          mem_q [DEPTH];
    fq_entry_t          mem_d [DEPTH];

    logic [INSTR_W-1:0] rom_dout;
    redir_sel_e         redir_sel;
    logic               redirect;
    logic [PC_W-1:0]    redir_target;
    fq_entry_t          newest;
    fq_entry_t          head;
    logic               head_valid;
    logic               pop, q_pop, bypass, push, issue;
    logic [OCC_W-1:0]   occ, lim;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    inst_rom_sync #(
        .ROM_AW (ROM_AW),
        .INIT   (ROM_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (pc_q[ROM_AW+1:2]),
        .dout (rom_dout)
    );

    always_comb begin
        if (jump_reg) begin
            redir_sel = JR;
        end else if (jump) begin
            redir_sel = J;
        end else if (branch_taken) begin
            redir_sel = BR;
        end else begin
            redir_sel = NONE;
        end
        case (redir_sel)
            JR:      redir_target = jr_addr;
            J:       redir_target = jump_addr;
            BR:      redir_target = branch_addr;
            default: redir_target = '0;
        endcase
        redirect = (redir_sel != NONE);
    end

    // Head: oldest queued entry, else the ROM word arriving this cycle.
    always_comb begin
        newest.pc    = PC_W_MAX'(ipc_q);
        newest.instr = rom_dout;
        head         = '0;
        head_valid   = 1'b0;
        if (count_q != '0) begin
            head       = mem_q[rd_ptr_q];
            head_valid = 1'b1;
        end else if (inflight_q) begin
            head       = newest;
            head_valid = 1'b1;
        end
    end

    always_comb begin
        pop    = head_valid & id_ready;
        q_pop  = pop & (count_q != '0);
        bypass = pop & (count_q == '0);
        push   = inflight_q & ~bypass;
        // Issue only while a slot is guaranteed for the result, counting the
        // slot freed by this cycle's pop.
        occ    = OCC_W'(count_q) + OCC_W'(inflight_q);
        lim    = OCC_W'(DEPTH) + OCC_W'(pop);
        issue  = (occ < lim);
    end

    always_comb begin
        pc_d       = pc_q;
        ipc_d      = ipc_q;
        inflight_d = 1'b0;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_d      = mem_q;
        if (redirect) begin
            // The fetch started this cycle is wrong-path; drop it with the queue.
            pc_d     = redir_target;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d       = pc_q + PC_W'(PC_STEP);
                ipc_d      = pc_q;
                inflight_d = 1'b1;
            end
            if (push) begin
                mem_d[wr_ptr_q] = newest;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (q_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(q_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            ipc_q      <= ipc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_q      <= mem_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count_q == FULL_CNT)));

    assign if_valid    = head_valid;
    assign instr_out   = head.instr;
    assign pc_out      = head.pc[PC_W-1:0];
    assign next_pc_out = head_valid ? (head.pc[PC_W-1:0] + PC_W'(PC_STEP)) : '0;

endmodule
